// File: rtl/seq_mult.sv
// Iterative radix-2 shift-add multiplier, N x N -> 2N bits.
// Signed operation multiplies operand magnitudes and negates the product
// when the operand signs differ. One operation takes N+1 clocks from the
// accepting edge to the edge that raises done.
module seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(N);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude of an N-bit operand; the most negative value maps onto 2^(N-1).
  function automatic logic [N-1:0] mag_n(input logic [N-1:0] v, input logic sgn);
    logic [N-1:0] m;
    if (sgn && v[N-1]) begin
      m = (~v) + {{(N-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Two's complement negation over the full product width.
  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
    return (~v) + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r;
  logic [N-1:0]     mcand_r;
  logic [2*N-1:0]   mplier_r;
  logic [2*N-1:0]   acc_r;
  logic [CW-1:0]    count_r;
  logic             neg_r;
  logic             busy_r;
  logic             done_r;
  logic [2*N-1:0]   result_r;

  logic [N-1:0]     a_mag_s;
  logic [N-1:0]     b_mag_s;
  logic             neg_s;
  logic [2*N-1:0]   addend_s;
  logic [2*N-1:0]   acc_next_s;

  // Operand magnitudes at acceptance and the partial-product add for one iteration.
  always_comb begin
    a_mag_s    = mag_n(a, is_signed);
    b_mag_s    = mag_n(b, is_signed);
    neg_s      = is_signed & (a[N-1] ^ b[N-1]);
    addend_s   = {(2*N){1'b0}};
    if (mcand_r[0]) begin
      addend_s = mplier_r;
    end else begin
      addend_s = {(2*N){1'b0}};
    end
    acc_next_s = acc_r + addend_s;
  end

  // Control FSM with datapath registers and registered busy/done/result.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r  <= IDLE;
      mcand_r  <= {N{1'b0}};
      mplier_r <= {(2*N){1'b0}};
      acc_r    <= {(2*N){1'b0}};
      count_r  <= {CW{1'b0}};
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {(2*N){1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r  <= BUSY;
            busy_r   <= 1'b1;
            mcand_r  <= a_mag_s;
            mplier_r <= {{N{1'b0}}, b_mag_s};
            neg_r    <= neg_s;
            acc_r    <= {(2*N){1'b0}};
            count_r  <= {CW{1'b0}};
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        BUSY: begin
          if (count_r == COUNT_LAST) begin
            // All multiplicand bits consumed: apply the sign and publish.
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            if (neg_r) begin
              result_r <= neg_2n(acc_r);
            end else begin
              result_r <= acc_r;
            end
          end else begin
            // mplier_r tracks |b| << count, mcand_r[0] tracks |a|[count].
            acc_r    <= acc_next_s;
            mcand_r  <= {1'b0, mcand_r[N-1:1]};
            mplier_r <= {mplier_r[2*N-2:0], 1'b0};
            count_r  <= count_r + COUNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: an N=8 and an N=4 instance, directed
// corner cases plus random operations against an integer reference product.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        start8, sgn8, start4, sgn4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] res8;
  logic [7:0]  res4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult #(.N(8)) dut8 (
    .clk(clk), .n_reset(n_reset), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8)
  );

  seq_mult #(.N(4)) dut4 (
    .clk(clk), .n_reset(n_reset), .start(start4), .is_signed(sgn4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .result(res4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain integer arithmetic, truncated to 2n bits.
  function automatic logic [31:0] ref_prod(input bit w4, input logic [7:0] x, input logic [7:0] y,
                                           input bit s);
    int n, xv, yv;
    n  = w4 ? 4 : 8;
    xv = int'(x) & ((1 << n) - 1);
    yv = int'(y) & ((1 << n) - 1);
    if (s) begin
      if (xv >= (1 << (n - 1))) xv -= (1 << n);
      if (yv >= (1 << (n - 1))) yv -= (1 << n);
    end
    return 32'((xv * yv) & ((1 << (2 * n)) - 1));
  endfunction

  task automatic drive(input bit w4, input bit st, input logic [7:0] x, input logic [7:0] y,
                       input bit s);
    if (w4) begin
      start4 = st; a4 = x[3:0]; b4 = y[3:0]; sgn4 = s;
    end else begin
      start8 = st; a8 = x; b8 = y; sgn8 = s;
    end
  endtask

  // Present an operation and let the accepting edge pass.
  task automatic launch(input bit w4, input logic [7:0] x, input logic [7:0] y, input bit s);
    drive(w4, 1'b1, x, y, s);
    @(posedge clk); #1;
  endtask

  // Called just after the accepting edge: scribbles the inputs, then follows
  // the operation to done, checking latency, busy span, result hold and product.
  task automatic watch(input string tag, input bit w4, input logic [31:0] exp,
                       input logic [7:0] jx, input logic [7:0] jy, input bit s, input bit hold);
    int n, lat, bcnt;
    bit both, moved, bs, ds;
    logic [31:0] prev, cur;
    n = w4 ? 4 : 8;
    lat = -1; bcnt = 0; both = 1'b0; moved = 1'b0;
    prev = w4 ? {24'd0, res4} : {16'd0, res8};
    drive(w4, hold, jx, jy, s);
    for (int k = 0; k <= 3 * n + 10; k++) begin
      bs  = w4 ? busy4 : busy8;
      ds  = w4 ? done4 : done8;
      cur = w4 ? {24'd0, res4} : {16'd0, res8};
      if (bs && ds) both = 1'b1;
      if (bs) bcnt++;
      if (ds) begin
        lat = k;
        break;
      end
      if (cur !== prev) moved = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(n + 1));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(n + 1));
    chk({tag, " busy_done_overlap"}, 32'(both), 32'd0);
    chk({tag, " result_held"}, 32'(moved), 32'd0);
    chk({tag, " result"}, w4 ? {24'd0, res4} : {16'd0, res8}, exp);
    if (!hold) begin
      @(posedge clk); #1;
      chk({tag, " after_done"}, w4 ? {30'd0, busy4, done4} : {30'd0, busy8, done8}, 32'd0);
    end
  endtask

  task automatic op(input string tag, input bit w4, input logic [7:0] x, input logic [7:0] y,
                    input bit s);
    launch(w4, x, y, s);
    watch(tag, w4, ref_prod(w4, x, y, s), 8'($urandom), 8'($urandom), s, 1'b0);
  endtask

  initial begin
    bit seen;
    logic [7:0] rx, ry;
    bit rs;
    n_reset = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    #3;
    chk("reset8", {15'd0, busy8, done8, res8}, 32'd0);
    chk("reset4", {23'd0, busy4, done4, res4}, 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;

    op("s5x4",       1'b0, 8'd5,   8'd4,   1'b1);
    op("s-3x5",      1'b0, 8'hFD,  8'd5,   1'b1);
    op("s-128x-128", 1'b0, 8'h80,  8'h80,  1'b1);
    op("u255x255",   1'b0, 8'hFF,  8'hFF,  1'b0);
    op("s-1x-1",     1'b0, 8'hFF,  8'hFF,  1'b1);
    op("u0x200",     1'b0, 8'd0,   8'd200, 1'b0);
    op("s127x-128",  1'b0, 8'h7F,  8'h80,  1'b1);

    // start held through BUSY with operands changed to 7,7, then back-to-back.
    launch(1'b0, 8'hF6, 8'd3, 1'b1);
    watch("hold_first", 1'b0, ref_prod(1'b0, 8'hF6, 8'd3, 1'b1), 8'd7, 8'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    watch("hold_second", 1'b0, 32'h0031, 8'd7, 8'd7, 1'b1, 1'b0);

    // Reset in the middle of an operation.
    launch(1'b0, 8'd9, 8'd9, 1'b0);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    chk("midreset8", {15'd0, busy8, done8, res8}, 32'd0);
    chk("midreset4", {23'd0, busy4, done4, res4}, 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done8 || busy8) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("no_done_after_reset", 32'(seen), 32'd0);
    op("u2x3", 1'b0, 8'd2, 8'd3, 1'b0);

    // N=4 instance corners.
    op("n4 s-8x-8", 1'b1, 8'h08, 8'h08, 1'b1);
    op("n4 u15x15", 1'b1, 8'h0F, 8'h0F, 1'b0);
    op("n4 s7x-8",  1'b1, 8'h07, 8'h08, 1'b1);

    // Random operations on both widths.
    for (int i = 0; i < 16; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom);
      op("rand8", 1'b0, rx, ry, rs);
    end
    for (int i = 0; i < 12; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom);
      op("rand4", 1'b1, rx, ry, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
